dram_ls_sequencer: RTL and testbench

Shares the single-port data RAM between the two issue slots of the dual-issue core. It accepts one issue group (slot0 older, slot1 younger) per handshake and serialises the group's load/store operations to the RAM in program order (slot0 then slot1). It also forms byte enables, replicates store data, and aligns and extends load data. The core holds the group in MEM stage until the done pulse.

---
 rtl/dram_pkg.sv | 40 ++++
 rtl/dram_load_align.sv | 26 ++
 rtl/dram_ls_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dram_ls_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared encodings and helpers for the data RAM load/store sequencer
package dram_pkg;

    localparam logic [2:0] MSK_W    = 3'b110;
    localparam logic [2:0] MSK_HS   = 3'b101;
    localparam logic [2:0] MSK_HU   = 3'b001;
    localparam logic [2:0] MSK_BS   = 3'b100;
    localparam logic [2:0] MSK_BU   = 3'b000;
    localparam logic [2:0] MSK_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Halves are 001/101 and bytes 000/100, so only the low two code bits select the size.
    function automatic logic [3:0] be_gen(input logic [2:0] mask, input logic [1:0] a);
        logic [3:0] be;
        if (mask == MSK_W) begin
            be = 4'b1111;
        end else if (mask[1:0] == 2'b01) begin
            be = 4'b0011 << {a[1], 1'b0};
        end else begin
            be = 4'b0001 << a;
        end
        return be;
    endfunction

    function automatic logic slot_illegal(input logic rd, input logic wr,
                                          input logic [2:0] mask, input logic [1:0] a);
        logic bad_code;
        logic bad_align;
        bad_code  = mask[1] && (mask != MSK_W);
        bad_align = ((mask[1:0] == 2'b01) && a[0]) || ((mask == MSK_W) && (a != 2'b00));
        return (rd || wr) && ((rd && wr) || bad_code || bad_align);
    endfunction

endpackage

// File: rtl/dram_load_align.sv
// rtl/dram_load_align.sv - selects and extends the addressed byte/half of a RAM read word
module dram_load_align
    import dram_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mask,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        if (mask == MSK_W) begin
            result = rdata;
        end else if (mask[1:0] == 2'b01) begin
            result = {{16{mask[2] & h[15]}}, h};
        end else begin
            result = {{24{mask[2] & b[7]}}, b};
        end
    end

endmodule

// File: rtl/dram_ls_sequencer.sv
// rtl/dram_ls_sequencer.sv - serialises a dual-issue group's loads/stores onto one RAM port
module dram_ls_sequencer
    import dram_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grp_valid,
    output logic          grp_ready,
    input  logic          s0_read,
    input  logic          s0_write,
    input  logic [2:0]    s0_mask,
    input  logic [AW-1:0] s0_addr,
    input  logic [31:0]   s0_wdata,
    output logic [31:0]   s0_rdata,
    output logic          s0_err,
    input  logic          s1_read,
    input  logic          s1_write,
    input  logic [2:0]    s1_mask,
    input  logic [AW-1:0] s1_addr,
    input  logic [31:0]   s1_wdata,
    output logic [31:0]   s1_rdata,
    output logic          s1_err,
    output logic          grp_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_be,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    state_t                state_q, state_d;
    logic                  cur_q, cur_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [1:0]            rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [1:0][2:0]       mask_q, mask_d;
    logic [1:0][AW-1:0]    addr_q, addr_d;
    logic [1:0][31:0]      wdata_q, wdata_d, rdata_q, rdata_d;

    logic                  c_rd, c_wr, c_empty, c_bad, c_go;
    logic [2:0]            c_mask;
    logic [AW-1:0]         c_addr;
    logic [31:0]           c_wdata, c_repl, ld_res;

    assign c_rd    = rd_q[cur_q];
    assign c_wr    = wr_q[cur_q];
    assign c_mask  = mask_q[cur_q];
    assign c_addr  = addr_q[cur_q];
    assign c_wdata = wdata_q[cur_q];
    assign c_empty = !c_rd && !c_wr;
    assign c_bad   = slot_illegal(c_rd, c_wr, c_mask, c_addr[1:0]);
    assign c_go    = (state_q == ST_ISSUE) && !c_empty && !c_bad;

    assign c_repl = (c_mask == MSK_W)        ? c_wdata :
                    (c_mask[1:0] == 2'b01)   ? {2{c_wdata[15:0]}} :
                                               {4{c_wdata[7:0]}};

    dram_load_align u_align (
        .rdata  (ram_rdata),
        .addr   (c_addr[1:0]),
        .mask   (c_mask),
        .result (ld_res)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        wcnt_d  = wcnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grp_valid) begin
                    rd_d    = {s1_read, s0_read};
                    wr_d    = {s1_write, s0_write};
                    mask_d  = {s1_mask, s0_mask};
                    addr_d  = {s1_addr, s0_addr};
                    wdata_d = {s1_wdata, s0_wdata};
                    rdata_d = '0;
                    err_d   = '0;
                    cur_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (c_bad) begin
                    err_d[cur_q] = 1'b1;
                end
                if (c_go && c_rd) begin
                    wcnt_d  = 2'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end else if (!cur_q) begin
                    cur_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    rdata_d[cur_q] = ld_res;
                    if (!cur_q) begin
                        cur_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= 1'b0;
            wcnt_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign grp_ready = (state_q == ST_IDLE);
    assign grp_done  = (state_q == ST_DONE);
    assign s0_rdata  = rdata_q[0];
    assign s1_rdata  = rdata_q[1];
    assign s0_err    = err_q[0];
    assign s1_err    = err_q[1];
    assign ram_en    = c_go;
    assign ram_we    = c_go && c_wr;
    assign ram_addr  = c_go ? {c_addr[AW-1:2], 2'b00} : '0;
    assign ram_be    = c_go ? be_gen(c_mask, c_addr[1:0]) : 4'b0000;
    assign ram_wdata = c_go ? c_repl : 32'h0;

endmodule

// File: tb/tb_dram_ls_sequencer.sv
// tb/tb_dram_ls_sequencer.sv - scoreboard bench for dram_ls_sequencer at RD_LAT 1 and 3
module tb_dram_ls_sequencer;

    localparam logic [2:0] LW  = 3'b110;
    localparam logic [2:0] LHS = 3'b101;
    localparam logic [2:0] LHU = 3'b001;
    localparam logic [2:0] LBS = 3'b100;
    localparam logic [2:0] LBU = 3'b000;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic        e0;
        logic        e1;
        int          cyc;
    } grp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } ram_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        grp_valid_a = 1'b0, grp_valid_b = 1'b0;
    logic        s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [2:0]  s0_mask = 3'b000, s1_mask = 3'b000;
    logic [31:0] s0_addr = 32'h0, s1_addr = 32'h0, s0_wdata = 32'h0, s1_wdata = 32'h0;

    logic        grp_ready_a, grp_done_a, s0_err_a, s1_err_a, ram_en_a, ram_we_a;
    logic [31:0] s0_rdata_a, s1_rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic [3:0]  ram_be_a;
    logic        grp_ready_b, grp_done_b, s0_err_b, s1_err_b, ram_en_b, ram_we_b;
    logic [31:0] s0_rdata_b, s1_rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic [3:0]  ram_be_b;

    logic [31:0] mem [0:511];
    logic [31:0] rd_a;
    logic [31:0] pb0, pb1, pb2;

    grp_exp_t grp_q[$];
    ram_exp_t ram_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_ls_sequencer #(.RD_LAT(1), .AW(32)) u_lat1 (
        .clk(clk), .rst(rst), .grp_valid(grp_valid_a), .grp_ready(grp_ready_a),
        .s0_read(s0_read), .s0_write(s0_write), .s0_mask(s0_mask), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_rdata(s0_rdata_a), .s0_err(s0_err_a),
        .s1_read(s1_read), .s1_write(s1_write), .s1_mask(s1_mask), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_rdata(s1_rdata_a), .s1_err(s1_err_a),
        .grp_done(grp_done_a), .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
        .ram_be(ram_be_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    dram_ls_sequencer #(.RD_LAT(3), .AW(32)) u_lat3 (
        .clk(clk), .rst(rst), .grp_valid(grp_valid_b), .grp_ready(grp_ready_b),
        .s0_read(s0_read), .s0_write(s0_write), .s0_mask(s0_mask), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_rdata(s0_rdata_b), .s0_err(s0_err_b),
        .s1_read(s1_read), .s1_write(s1_write), .s1_mask(s1_mask), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_rdata(s1_rdata_b), .s1_err(s1_err_b),
        .grp_done(grp_done_b), .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
        .ram_be(ram_be_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    // Shared RAM model; only one sequencer is ever active at a time.
    always @(posedge clk) begin
        if (rst) begin
            mem[128] <= 32'h80FF7F01;
            mem[320] <= 32'hFFFE0000;
        end
        if (ram_en_a) begin
            if (ram_we_a) begin
                for (int i = 0; i < 4; i++)
                    if (ram_be_a[i]) mem[ram_addr_a[10:2]][8*i +: 8] <= ram_wdata_a[8*i +: 8];
            end else begin
                rd_a <= mem[ram_addr_a[10:2]];
            end
        end
        if (ram_en_b) begin
            if (ram_we_b) begin
                for (int i = 0; i < 4; i++)
                    if (ram_be_b[i]) mem[ram_addr_b[10:2]][8*i +: 8] <= ram_wdata_b[8*i +: 8];
            end else begin
                pb0 <= mem[ram_addr_b[10:2]];
            end
        end
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ram_rdata_a = rd_a;
    assign ram_rdata_b = pb2;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_grp(logic [31:0] r0, logic [31:0] r1, logic e0, logic e1, int c);
        grp_exp_t e;
        e.r0 = r0; e.r1 = r1; e.e0 = e0; e.e1 = e1; e.cyc = c;
        grp_q.push_back(e);
    endfunction

    function automatic void push_ram(logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd, int c);
        ram_exp_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.cyc = c;
        ram_q.push_back(e);
    endfunction

    function automatic void mon_done(logic [31:0] r0, logic [31:0] r1, logic e0, logic e1);
        grp_exp_t e;
        if (grp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got grp_done=1 expected no done (cycle %0d)", cyc);
        end else begin
            e = grp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("s0_rdata", r0, e.r0);
            chk("s1_rdata", r1, e.r1);
            chk("s0_err", {31'h0, e0}, {31'h0, e.e0});
            chk("s1_err", {31'h0, e1}, {31'h0, e.e1});
        end
    endfunction

    function automatic void mon_ram(logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
        ram_exp_t e;
        if (ram_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ram_en: got access addr %h we %b expected none (cycle %0d)", a, we, cyc);
        end else begin
            e = ram_q.pop_front();
            chk("ram_cycle", cyc, e.cyc);
            chk("ram_we", {31'h0, we}, {31'h0, e.we});
            chk("ram_addr", a, e.addr);
            chk("ram_be", {28'h0, be}, {28'h0, e.be});
            chk("ram_wdata", wd, e.wdata);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (grp_done_a) mon_done(s0_rdata_a, s1_rdata_a, s0_err_a, s1_err_a);
            if (grp_done_b) mon_done(s0_rdata_b, s1_rdata_b, s0_err_b, s1_err_b);
            if (ram_en_a) mon_ram(ram_we_a, ram_addr_a, ram_be_a, ram_wdata_a);
            if (ram_en_b) mon_ram(ram_we_b, ram_addr_b, ram_be_b, ram_wdata_b);
        end
    end

    // Presents a group at a negedge once the chosen instance is idle; tc is the accept cycle.
    task automatic start_group(input bit inst,
                               input logic r0, input logic w0, input logic [2:0] m0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [2:0] m1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               output int tc);
        int n = 0;
        @(negedge clk);
        while (!(inst ? grp_ready_b : grp_ready_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got grp_ready=0 expected 1 within 50 cycles");
        end
        s0_read = r0; s0_write = w0; s0_mask = m0; s0_addr = a0; s0_wdata = d0;
        s1_read = r1; s1_write = w1; s1_mask = m1; s1_addr = a1; s1_wdata = d1;
        if (inst) grp_valid_b = 1'b1;
        else      grp_valid_a = 1'b1;
        tc = cyc;
    endtask

    task automatic end_valid();
        @(negedge clk);
        grp_valid_a = 1'b0;
        grp_valid_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((grp_q.size() != 0 || ram_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d groups %0d accesses pending expected 0",
                     grp_q.size(), ram_q.size());
            grp_q.delete();
            ram_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready_a", {31'h0, grp_ready_a}, 32'h1);
        chk("rst_ready_b", {31'h0, grp_ready_b}, 32'h1);
        chk("rst_ram_en", {31'h0, ram_en_a}, 32'h0);
        chk("rst_done", {31'h0, grp_done_a}, 32'h0);
        chk("rst_s0_rdata", s0_rdata_a, 32'h0);
        chk("rst_s1_err", {31'h0, s1_err_a}, 32'h0);
        rst = 1'b0;

        // Load aborted by an asynchronous reset in its WAIT cycle.
        start_group(1'b0, 1, 0, LW, 32'h100, 0, 0, 0, LBU, 0, 0, t);
        push_ram(0, 32'h100, 4'hF, 32'h0, t + 1);
        end_valid();
        @(negedge clk);
        chk("wait_busy", {31'h0, grp_ready_a}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, grp_ready_a}, 32'h1);
        chk("midrst_ram_en", {31'h0, ram_en_a}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();

        start_group(1'b0, 0, 1, LW, 32'h100, 32'hDEADBEEF, 0, 1, LBU, 32'h103, 32'h55, t);
        push_ram(1, 32'h100, 4'hF, 32'hDEADBEEF, t + 1);
        push_ram(1, 32'h100, 4'h8, 32'h55555555, t + 2);
        push_grp(0, 0, 0, 0, t + 3);
        end_valid();
        drain();

        start_group(1'b0, 1, 0, LBS, 32'h203, 0, 1, 0, LHU, 32'h202, 0, t);
        push_ram(0, 32'h200, 4'h8, 32'h0, t + 1);
        push_ram(0, 32'h200, 4'hC, 32'h0, t + 3);
        push_grp(32'hFFFFFF80, 32'h000080FF, 0, 0, t + 5);
        end_valid();
        drain();

        start_group(1'b0, 0, 1, LW, 32'h300, 32'h12345678, 1, 0, LW, 32'h300, 0, t);
        push_ram(1, 32'h300, 4'hF, 32'h12345678, t + 1);
        push_ram(0, 32'h300, 4'hF, 32'h0, t + 2);
        push_grp(0, 32'h12345678, 0, 0, t + 4);
        end_valid();
        drain();

        start_group(1'b0, 1, 0, LW, 32'h401, 0, 1, 0, LHS, 32'h405, 0, t);
        push_grp(0, 0, 1, 1, t + 3);
        end_valid();
        drain();

        start_group(1'b0, 1, 1, LW, 32'h700, 0, 1, 0, 3'b010, 32'h704, 0, t);
        push_grp(0, 0, 1, 1, t + 3);
        end_valid();
        drain();

        start_group(1'b0, 0, 1, LHU, 32'h602, 32'hABCD1234, 1, 0, LBU, 32'h603, 0, t);
        push_ram(1, 32'h600, 4'hC, 32'h12341234, t + 1);
        push_ram(0, 32'h600, 4'h8, 32'h0, t + 2);
        push_grp(0, 32'h00000012, 0, 0, t + 4);
        end_valid();
        drain();

        // RD_LAT=3 instance; valid and slot inputs wiggle while busy and must be ignored.
        start_group(1'b1, 0, 0, LBU, 0, 0, 1, 0, LHS, 32'h502, 0, t);
        push_ram(0, 32'h500, 4'hC, 32'h0, t + 2);
        push_grp(0, 32'hFFFFFFFE, 0, 0, t + 6);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            grp_valid_b = k[0];
            s1_addr = 32'h0;
            s1_mask = LW;
        end
        @(negedge clk);
        grp_valid_b = 1'b0;
        drain();

        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
